// File: rtl/dt_stack_ctrl_pkg.sv
// Shared command encodings, command width and FSM state codes for the data-stack engine.
package dt_stack_ctrl_pkg;

  localparam int unsigned SC_N = 3;

  typedef enum logic [SC_N-1:0] {
    SC_NON = 3'd0,
    SC_PUS = 3'd1,
    SC_POP = 3'd2,
    SC_TOP = 3'd3,
    SC_SWP = 3'd4,
    SC_CLR = 3'd5
  } sc_cmd_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SWP2 = 1'b1
  } sc_state_e;

endpackage

// File: rtl/dt_stack_ctrl_if.sv
// Command/response bundle between the controller FSM (master) and the stack engine (slave).
interface dt_stack_ctrl_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned CW    = 3
);
  localparam int unsigned PW = $clog2(DEPTH + 1);

  logic [CW-1:0]    cmd;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] dout;
  logic             rsp_valid;
  logic [PW-1:0]    count;
  logic             empty;
  logic             full;
  logic             ovf;
  logic             unf;

  modport master (
    output cmd, cmd_valid, din,
    input  cmd_ready, dout, rsp_valid, count, empty, full, ovf, unf
  );

  modport slave (
    input  cmd, cmd_valid, din,
    output cmd_ready, dout, rsp_valid, count, empty, full, ovf, unf
  );
endinterface

// File: rtl/dt_stack_ram.sv
// Stack storage: synchronous single write port, two asynchronous read ports, no reset.
module dt_stack_ram #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr0,
  output logic [WIDTH-1:0] rdata0,
  input  logic [AW-1:0]    raddr1,
  output logic [WIDTH-1:0] rdata1
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata0 = mem[raddr0];
  assign rdata1 = mem[raddr1];

endmodule

// File: rtl/dt_stack_ctrl.sv
// Data-stack engine: push/pop/peek/swap/clear with registered result, depth status and sticky flags.
module dt_stack_ctrl
  import dt_stack_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned CW    = SC_N
) (
  input  logic            Clock,
  input  logic            Reset,
  dt_stack_ctrl_if.slave  bus
);

  localparam int unsigned PW = $clog2(DEPTH + 1);
  localparam int unsigned AW = $clog2(DEPTH);

  sc_state_e        state_q, state_d;
  logic [PW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             rsp_q, rsp_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic [WIDTH-1:0] tmp_q, tmp_d;

  logic             we_c;
  logic [AW-1:0]    waddr_c;
  logic [WIDTH-1:0] wdata_c;
  logic [AW-1:0]    idx1_c, idx2_c;
  logic [WIDTH-1:0] rd1_c, rd2_c;
  logic             empty_c, full_c;

  assign idx1_c  = AW'(count_q - PW'(1));
  assign idx2_c  = AW'(count_q - PW'(2));
  assign empty_c = (count_q == '0);
  assign full_c  = (count_q == PW'(DEPTH));

  // Reset blocks the write so an aborted swap cannot disturb storage in the reset cycle.
  dt_stack_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk    (Clock),
    .we     (we_c & Reset),
    .waddr  (waddr_c),
    .wdata  (wdata_c),
    .raddr0 (idx1_c),
    .rdata0 (rd1_c),
    .raddr1 (idx2_c),
    .rdata1 (rd2_c)
  );

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      dout_q  <= '0;
      rsp_q   <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      dout_q  <= dout_d;
      rsp_q   <= rsp_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Swap holding register carries the old top word into the second swap cycle.
  always_ff @(posedge Clock) begin
    tmp_q <= tmp_d;
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    dout_d  = dout_q;
    rsp_d   = 1'b0;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    tmp_d   = tmp_q;
    we_c    = 1'b0;
    waddr_c = AW'(count_q);
    wdata_c = bus.din;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.cmd_valid) begin
          case (bus.cmd)
            CW'(SC_PUS): begin
              if (!full_c) begin
                we_c    = 1'b1;
                waddr_c = AW'(count_q);
                wdata_c = bus.din;
                count_d = count_q + PW'(1);
              end else begin
                ovf_d = 1'b1;
              end
            end
            CW'(SC_POP), CW'(SC_TOP): begin
              rsp_d = 1'b1;
              if (!empty_c) begin
                dout_d = rd1_c;
                if (bus.cmd == CW'(SC_POP)) count_d = count_q - PW'(1);
              end else begin
                dout_d = '0;
                unf_d  = 1'b1;
              end
            end
            CW'(SC_SWP): begin
              if (count_q >= PW'(2)) begin
                tmp_d   = rd1_c;
                we_c    = 1'b1;
                waddr_c = idx1_c;
                wdata_c = rd2_c;
                state_d = ST_SWP2;
              end else begin
                unf_d = 1'b1;
              end
            end
            CW'(SC_CLR): begin
              count_d = '0;
              ovf_d   = 1'b0;
              unf_d   = 1'b0;
              dout_d  = '0;
            end
            default: ;
          endcase
        end
      end
      ST_SWP2: begin
        we_c    = 1'b1;
        waddr_c = idx2_c;
        wdata_c = tmp_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.cmd_ready = (state_q == ST_IDLE);
  assign bus.dout      = dout_q;
  assign bus.rsp_valid = rsp_q;
  assign bus.count     = count_q;
  assign bus.empty     = empty_c;
  assign bus.full      = full_c;
  assign bus.ovf       = ovf_q;
  assign bus.unf       = unf_q;

endmodule

// File: tb/tb_dt_stack_ctrl.sv
// Scoreboard bench for dt_stack_ctrl at WIDTH=8, DEPTH=4.
module tb_dt_stack_ctrl;
  import dt_stack_ctrl_pkg::*;

  localparam int unsigned W = 8;
  localparam int unsigned D = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;

  typedef struct {
    logic [W-1:0] data;
    int           due;
  } exp_t;
  exp_t sb[$];

  logic [W-1:0] m_mem [D];
  int           m_cnt = 0;
  logic         m_ovf = 1'b0;
  logic         m_unf = 1'b0;
  logic [W-1:0] m_dout = '0;
  logic         m_busy = 1'b0;

  dt_stack_ctrl_if #(.WIDTH(W), .DEPTH(D), .CW(3)) bus ();

  dt_stack_ctrl #(.WIDTH(W), .DEPTH(D), .CW(3)) dut (
    .Clock (clk),
    .Reset (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; m_ovf = 1'b0; m_unf = 1'b0; m_dout = '0; m_busy = 1'b0;
  endtask

  task automatic model_apply(input logic [2:0] c, input logic [W-1:0] d);
    logic [W-1:0] t;
    exp_t e;
    m_busy = 1'b0;
    case (c)
      3'd1: if (m_cnt < D) begin m_mem[m_cnt] = d; m_cnt++; end else m_ovf = 1'b1;
      3'd2, 3'd3: begin
        if (m_cnt > 0) begin
          m_dout = m_mem[m_cnt-1];
          if (c == 3'd2) m_cnt--;
        end else begin
          m_dout = '0; m_unf = 1'b1;
        end
        e.data = m_dout; e.due = cyc;
        sb.push_back(e);
      end
      3'd4: if (m_cnt >= 2) begin
        t = m_mem[m_cnt-1]; m_mem[m_cnt-1] = m_mem[m_cnt-2]; m_mem[m_cnt-2] = t;
        m_busy = 1'b1;
      end else m_unf = 1'b1;
      3'd5: begin m_cnt = 0; m_ovf = 1'b0; m_unf = 1'b0; m_dout = '0; end
      default: ;
    endcase
  endtask

  task automatic check_status();
    check_eq("count", 32'(bus.count), 32'(m_cnt));
    check_eq("empty", 32'(bus.empty), 32'(m_cnt == 0));
    check_eq("full",  32'(bus.full),  32'(m_cnt == D));
    check_eq("ovf",   32'(bus.ovf),   32'(m_ovf));
    check_eq("unf",   32'(bus.unf),   32'(m_unf));
    check_eq("dout",  32'(bus.dout),  32'(m_dout));
    check_eq("cmd_ready", 32'(bus.cmd_ready), 32'(!m_busy));
  endtask

  // Presents a command from a falling edge and holds it until the rising edge that accepts it.
  task automatic issue(input logic [2:0] c, input logic [W-1:0] d, output int stalls);
    bit ok;
    ok = 1'b0;
    stalls = 0;
    @(negedge clk);
    bus.cmd_valid = 1'b1; bus.cmd = c; bus.din = d;
    for (int i = 0; i < 20; i++) begin
      if (bus.cmd_ready) begin ok = 1'b1; break; end
      stalls++;
      @(negedge clk);
    end
    if (!ok) begin
      check_eq("ready_timeout", 32'd0, 32'd1);
      bus.cmd_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    model_apply(c, d);
    check_status();
  endtask

  task automatic do_cmd(input logic [2:0] c, input logic [W-1:0] d);
    int s;
    issue(c, d, s);
  endtask

  task automatic go_idle();
    @(negedge clk);
    bus.cmd_valid = 1'b0; bus.cmd = '0;
  endtask

  // Response monitor: every rsp_valid pulse must match the oldest expected POP/TOP result.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (bus.rsp_valid) begin
        if (sb.size() == 0) check_eq("rsp_spurious", 32'd1, 32'd0);
        else begin
          e = sb.pop_front();
          check_eq("rsp_data",  32'(bus.dout), 32'(e.data));
          check_eq("rsp_cycle", 32'(cyc),      32'(e.due));
        end
      end else if (sb.size() != 0 && sb[0].due <= cyc) begin
        e = sb.pop_front();
        check_eq("rsp_missing", 32'd0, 32'd1);
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    bus.cmd_valid = 1'b0; bus.cmd = '0; bus.din = '0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    check_status();
    check_eq("rsp_reset", 32'(bus.rsp_valid), 32'd0);
    rst_n = 1'b1;

    // Push two, peek back-to-back.
    do_cmd(3'd1, 8'h11);
    do_cmd(3'd1, 8'h22);
    do_cmd(3'd3, 8'h00);

    // Fill, overflow, drain.
    do_cmd(3'd5, 8'h00);
    for (int i = 1; i <= 5; i++) do_cmd(3'd1, W'(i));
    for (int i = 0; i < 4; i++) do_cmd(3'd2, 8'h00);

    // Underflow on empty, then clear; no-op commands.
    do_cmd(3'd2, 8'h00);
    do_cmd(3'd5, 8'h00);
    do_cmd(3'd0, 8'hEE);
    do_cmd(3'd6, 8'hEE);
    do_cmd(3'd7, 8'hEE);

    // Swap with a queued POP behind it.
    do_cmd(3'd1, 8'hAA);
    do_cmd(3'd1, 8'hBB);
    do_cmd(3'd4, 8'h00);
    issue(3'd2, 8'h00, s);
    check_eq("swp_stall", 32'(s), 32'd1);
    do_cmd(3'd2, 8'h00);

    // Swap with one entry.
    do_cmd(3'd1, 8'h77);
    do_cmd(3'd4, 8'h00);
    do_cmd(3'd3, 8'h00);
    do_cmd(3'd5, 8'h00);

    // Reset during the second swap cycle.
    do_cmd(3'd2, 8'h00);
    do_cmd(3'd1, 8'h01);
    do_cmd(3'd1, 8'h02);
    do_cmd(3'd4, 8'h00);
    rst_n = 1'b0;
    bus.cmd_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    check_status();
    do_cmd(3'd1, 8'h5A);
    do_cmd(3'd3, 8'h00);

    go_idle();
    repeat (3) @(negedge clk);
    check_eq("sb_drain", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
